hex_compare_sequencer: RTL and testbench
========================================

HEX_COMPARE_SEQUENCER -- requirements
Module: hex_compare_sequencer

Interface
REQ-001: Parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: start  input  1  request a comparison; accepted only in IDLE.
REQ-005: a  input  W  operand A, sampled on the accepting edge.
REQ-006: b  input  W  operand B, sampled on the accepting edge.
REQ-007: e, l, g  input  1 each  cascade inputs (equal/less/greater from lower-significance stage), sampled on the accepting edge.
REQ-008: busy  output  1  high while a comparison is in progress or completing.
REQ-009: done  output  1  one-cycle pulse; GT/LT/EQ valid and new.
REQ-010: GT, LT, EQ  output  1 each  registered result of A vs B, cascade-resolved.

Function
REQ-011: The block SHALL use a single 4-bit slice compare per cycle (one shared slice), iterated over NIBBLES slices.
REQ-012: States: IDLE, COMPARE, DONE; IDLE->COMPARE on start=1; COMPARE->DONE after the last slice; DONE->IDLE unconditionally next edge.
REQ-013: On the accepting edge E0, a, b, e, l, g SHALL be captured; running result initialised to {e,l,g}; slice counter cleared.
REQ-014: Without early termination, slices SHALL be processed LSB-first, one per edge E1..E_NIBBLES; per slice: a_nib>b_nib -> GT, a_nib<b_nib -> LT, equal -> running result passed unchanged.
REQ-015: Final result SHALL be registered on edge E_NIBBLES; done=1 and busy=1 in the following cycle (DONE); latency start-edge to done = NIBBLES+1 cycles.
REQ-016: Result SHALL equal the combinational 16-bit cascaded magnitude compare of the same a, b, e, l, g, including pass-through of e/l/g when A==B (non-one-hot cascade inputs pass through unchanged).
REQ-017: GT/LT/EQ SHALL hold their last value between completions; they change only on the edge entering DONE.
REQ-018: start while busy=1 (COMPARE or DONE) SHALL be ignored; no queuing; operands/cascade inputs not re-sampled.
REQ-019: start=1 held continuously SHALL yield back-to-back comparisons with exactly one IDLE cycle between DONE and next COMPARE.
REQ-020: Slice counter SHALL be ceil(log2(NIBBLES)) bits minimum and SHALL not wrap within a comparison.

Reset
REQ-021: rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, GT=0, LT=0, EQ=0, counter=0, regardless of state.
REQ-022: rst asserted mid-COMPARE SHALL abandon the operation; no done pulse SHALL follow.
REQ-023: rst has priority over start on the same edge.

Configuration
REQ-024: Macro HEX_CMP_EARLY_TERM_EN selects early termination.
REQ-025: With HEX_CMP_EARLY_TERM_EN defined: slices processed MSB-first; first unequal slice SHALL set GT or LT and move to DONE on that same edge; if all slices equal, result = captured {e,l,g} after NIBBLES slices; latency 2..NIBBLES+1 cycles.
REQ-026: Without the macro: fixed LSB-first schedule of REQ-014/015; latency always NIBBLES+1.
REQ-027: Final GT/LT/EQ SHALL be identical in both builds for identical inputs.

Verification
REQ-028: a=16'h1234, b=16'h1234, e=1,l=0,g=0, start pulse -> EQ=1, GT=0, LT=0, done after 5 cycles (both builds).
REQ-029: a=16'h8000, b=16'h7FFF, e=1 -> GT=1; done after 5 cycles without macro, after 2 cycles with HEX_CMP_EARLY_TERM_EN.
REQ-030: a=16'h0001, b=16'h0002, e=1 -> LT=1; done after 5 cycles in both builds.
REQ-031: a=b=16'hABCD, e=0,l=0,g=1 -> GT=1, EQ=0 (cascade pass-through).
REQ-032: start at E0, second start with a=16'hFFFF at E2 -> second ignored; result reflects first operands; one done pulse only.
REQ-033: rst at E2 of a comparison -> busy=0, outputs 0 next cycle, no done pulse; fresh start afterwards completes normally.

Source files
------------

// File: rtl/hex_compare_sequencer_if.sv
// Request/result bundle for hex_compare_sequencer.
// The master drives the request: start, the operands and the cascade inputs.
// The slave returns busy/done and the registered GT/LT/EQ result.
interface hex_compare_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         e;
  logic         l;
  logic         g;
  logic         busy;
  logic         done;
  logic         GT;
  logic         LT;
  logic         EQ;

  modport master (
    output start, a, b, e, l, g,
    input  busy, done, GT, LT, EQ
  );

  modport slave (
    input  start, a, b, e, l, g,
    output busy, done, GT, LT, EQ
  );
endinterface

// File: rtl/hex_compare_sequencer.sv
// Sequential cascaded magnitude comparator built around one shared 4-bit slice
// compare, iterated over NIBBLES slices of the operands.
// Optional macro HEX_CMP_EARLY_TERM_EN: walk the slices MSB-first and finish on
// the first unequal slice. Default build walks the slices LSB-first over a
// fixed schedule. Both builds produce the same GT/LT/EQ.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; operands and cascade captured on accept
// S_COMPARE | one slice compared per edge, running result updated
// S_DONE    | done pulse; GT/LT/EQ freshly loaded; back to idle next edge
module hex_compare_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  hex_compare_sequencer_if.slave   bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [2:0]    run_q;  // running result, ordered {eq, lt, gt}
  logic [2:0]    res_q;  // published result, ordered {eq, lt, gt}
  logic [CW-1:0] cnt_q;

  logic          capture;
  logic          step;
  logic          finish;
  logic [CW-1:0] idx;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [2:0]    slice_res;
  logic          last;
  logic          nib_ne;

  // Select the slice for this cycle and fold it into the running result.
  always_comb begin
`ifdef HEX_CMP_EARLY_TERM_EN
    idx = CW'(NIBBLES - 1) - cnt_q;
`else
    idx = cnt_q;
`endif
    a_nib  = a_q[{idx, 2'b00} +: 4];
    b_nib  = b_q[{idx, 2'b00} +: 4];
    nib_ne = (a_nib != b_nib);
    last   = (cnt_q == CW'(NIBBLES - 1));
    if (a_nib > b_nib) begin
      slice_res = 3'b001;
    end else if (a_nib < b_nib) begin
      slice_res = 3'b010;
    end else begin
      slice_res = run_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and datapath controls.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          capture  = 1'b1;
          state_nx = S_COMPARE;
        end
      end
      S_COMPARE: begin
        step = 1'b1;
`ifdef HEX_CMP_EARLY_TERM_EN
        // The most significant unequal slice decides; lower slices cannot matter.
        if (nib_ne || last) begin
          finish   = 1'b1;
          state_nx = S_DONE;
        end
`else
        if (last) begin
          finish   = 1'b1;
          state_nx = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Operand capture, slice counter, running and published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      run_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      if (capture) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        run_q <= {bus.e, bus.l, bus.g};
        cnt_q <= '0;
      end else if (step) begin
        run_q <= slice_res;
        // Hold at the last index so the counter never wraps mid-compare.
        if (!last) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (finish) begin
        res_q <= slice_res;
      end
    end
  end

  // Status and result outputs, all decoded from registers.
  always_comb begin
    bus.busy = (state != S_IDLE);
    bus.done = (state == S_DONE);
    bus.EQ   = res_q[2];
    bus.LT   = res_q[1];
    bus.GT   = res_q[0];
  end

endmodule

// File: tb/tb_hex_compare_sequencer.sv
// Self-checking bench for hex_compare_sequencer (NIBBLES = 4).
// Expected results come from a whole-word magnitude compare; expected latency
// from the position of the most significant differing nibble (early-term
// build) or the fixed schedule (default build).
module tb_hex_compare_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hex_compare_sequencer_if #(.NIBBLES(N)) bus ();

  hex_compare_sequencer #(.NIBBLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {eq, lt, gt}
  function automatic logic [2:0] ref_res(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                         input logic re, input logic rl, input logic rg);
    if (ra > rb) return 3'b001;
    if (ra < rb) return 3'b010;
    return {re, rl, rg};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] ra, input logic [W-1:0] rb);
`ifdef HEX_CMP_EARLY_TERM_EN
    for (int k = N - 1; k >= 0; k--) begin
      if (ra[k*4 +: 4] != rb[k*4 +: 4]) return (N - 1 - k) + 2;
    end
    return N + 1;
`else
    return N + 1;
`endif
  endfunction

  function automatic logic [2:0] obs_res();
    return {bus.EQ, bus.LT, bus.GT};
  endfunction

  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                         input logic te, input logic tl, input logic tg);
    logic [2:0] prev;
    logic [2:0] exp_r;
    int         exp_l;
    int         cyc;
    exp_r = ref_res(ta, tb2, te, tl, tg);
    exp_l = ref_lat(ta, tb2);
    @(negedge clk);
    prev      = obs_res();
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb2;
    bus.e     = te;
    bus.l     = tl;
    bus.g     = tg;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.e     = 1'($urandom);
    bus.l     = 1'($urandom);
    bus.g     = 1'($urandom);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      chk("busy_compare", bus.busy, 1);
      chk("result_hold_compare", obs_res(), prev);
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", bus.done, 1);
    chk("latency", cyc, exp_l);
    chk("busy_in_done", bus.busy, 1);
    chk("result", obs_res(), exp_r);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_after_done", bus.busy, 0);
    chk("result_hold_idle", obs_res(), exp_r);
  endtask

  initial begin
    int         ndone;
    int         when;
    int         cyc;
    logic [2:0] got;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int         sel;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.e     = 1'b0;
    bus.l     = 1'b0;
    bus.g     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_result", obs_res(), 3'b000);
    bus.start = 1'b1;
    @(negedge clk);
    chk("reset_beats_start", bus.busy, 0);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);

    // Directed vectors
    run_cmp(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);
    run_cmp(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    run_cmp(16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0);
    run_cmp(16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1);
    run_cmp(16'hABCD, 16'hABCD, 1'b1, 1'b1, 1'b0);
    run_cmp(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_cmp(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h0001;
    bus.b     = 16'h0002;
    bus.e     = 1'b1;
    bus.l     = 1'b0;
    bus.g     = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    when  = -1;
    got   = 3'b000;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) begin
        ndone++;
        if (when < 0) when = i;
        got = obs_res();
      end
      @(negedge clk);
    end
    chk("ignored_start_done_count", ndone, 1);
    chk("ignored_start_when", when, ref_lat(16'h0001, 16'h0002) - 3);
    chk("ignored_start_result", got, ref_res(16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0));

    // Reset mid-compare
    bus.start = 1'b1;
    bus.a     = 16'h0001;
    bus.b     = 16'h0002;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_done", bus.done, 0);
    chk("midreset_result", obs_res(), 3'b000);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    chk("midreset_no_done", ndone, 0);
    run_cmp(16'h4321, 16'h4312, 1'b1, 1'b0, 1'b0);

    // Start held high: back-to-back with one idle cycle between
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h1230;
    bus.e     = 1'b1;
    bus.l     = 1'b0;
    bus.g     = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_first_done", bus.done, 1);
    @(negedge clk);
    chk("b2b_gap_idle", bus.busy, 0);
    @(negedge clk);
    chk("b2b_restart", bus.busy, 1);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_second_latency", cyc, ref_lat(16'h1234, 16'h1230));
    chk("b2b_result", obs_res(), ref_res(16'h1234, 16'h1230, 1'b1, 1'b0, 1'b0));
    bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_stop_idle", bus.busy, 0);
    @(negedge clk);
    chk("b2b_stays_idle", bus.busy, 0);

    // Randomized vectors, biased toward equal and near-equal operands
    for (int it = 0; it < 60; it++) begin
      ra  = W'($urandom);
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        rb = ra;
      end else if (sel == 1) begin
        rb = ra;
        rb[$urandom_range(0, N - 1) * 4 +: 4] = 4'($urandom);
      end else begin
        rb = W'($urandom);
      end
      run_cmp(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
